// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset datapath: sequences fetch/decode/execute,
// drives datapath selects and strobes, counts retired instructions. Optional bne: MC_CTRL_BNE_EN.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl_sig,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_BNE, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state, next_state;
  logic       op_ok, funct_ok, retire;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    op_ok      = 1'b1;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       next_state = S_BNE;
`endif
          default: begin
            next_state = S_FETCH;
            op_ok      = 1'b0;
          end
        endcase
      end
      S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = funct_ok ? S_ALUWB : S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // A store retires only on the cycle its memory write is accepted.
  always_comb begin
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_BNE, S_ADDIWB, S_JUMP: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= next_state;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // Outputs decode the current state; gating on reset drops strobes without waiting for a clock.
  always_comb begin
    iord         = 1'b0;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_ctrl_sig = ALU_AND;
    pc_src       = 2'b00;
    pc_en        = 1'b0;
    illegal_op   = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req      = 1'b1;
          alu_src_b    = 2'b01;
          alu_ctrl_sig = ALU_ADD;
          ir_write     = mem_ready;
          pc_en        = mem_ready;
        end
        S_DECODE: begin
          alu_src_b    = 2'b11;
          alu_ctrl_sig = ALU_ADD;
          illegal_op   = ~op_ok;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          alu_ctrl_sig = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a    = 1'b1;
          alu_ctrl_sig = funct_alu;
          illegal_op   = ~funct_ok;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH, S_BNE: begin
          alu_src_a    = 1'b1;
          alu_ctrl_sig = ALU_SUB;
          pc_src       = 2'b01;
          pc_en        = (state == S_BNE) ? ~zero : zero;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each test queues per-cycle expected outputs and instret,
// then drains the queue against the DUT one clock at a time.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a, pc_en, illegal_op;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctrl_sig;
  logic [31:0] instret;
  logic [16:0] obs;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 0;

  typedef struct {
    string       name;
    logic [16:0] outs;
    logic [31:0] cnt;
    logic        rdy;
  } exp_t;

  exp_t sb[$];

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl_sig(alu_ctrl_sig),
    .pc_src(pc_src), .pc_en(pc_en), .illegal_op(illegal_op), .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_ctrl_sig, pc_src, pc_en, illegal_op};

  function automatic logic [16:0] pk(input logic mreq, input logic io, input logic mw,
      input logic irw, input logic rd, input logic m2r, input logic rw, input logic a,
      input logic [1:0] b, input logic [2:0] alu, input logic [1:0] ps, input logic pe,
      input logic ill);
    return {mreq, io, mw, irw, rd, m2r, rw, a, b, alu, ps, pe, ill};
  endfunction

  function automatic logic [16:0] e_fetch(input logic r);
    return pk(1, 0, 0, r, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, r, 0);
  endfunction
  function automatic logic [16:0] e_decode(input logic ill);
    return pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, ill);
  endfunction
  function automatic logic [16:0] e_exec(input logic [2:0] alu, input logic ill);
    return pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 2'b00, 0, ill);
  endfunction
  function automatic logic [16:0] e_branch(input logic pe);
    return pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, pe, 0);
  endfunction
  localparam logic [16:0] E_ZERO   = 17'h0;
  localparam logic [16:0] E_ADDR   = {8'b0000_0001, 2'b10, 3'b010, 4'b0000};
  localparam logic [16:0] E_MEMRD  = {8'b1100_0000, 2'b00, 3'b000, 4'b0000};
  localparam logic [16:0] E_MEMWB  = {8'b0000_0110, 2'b00, 3'b000, 4'b0000};
  localparam logic [16:0] E_MEMWR  = {8'b1110_0000, 2'b00, 3'b000, 4'b0000};
  localparam logic [16:0] E_ALUWB  = {8'b0000_1010, 2'b00, 3'b000, 4'b0000};
  localparam logic [16:0] E_ADDIWB = {8'b0000_0010, 2'b00, 3'b000, 4'b0000};
  localparam logic [16:0] E_JUMP   = {8'b0000_0000, 2'b00, 3'b000, 4'b1010};

  task automatic push(input string n, input logic [16:0] o, input logic r, input bit retire);
    exp_t e;
    e.name = n; e.outs = o; e.cnt = exp_cnt; e.rdy = r;
    sb.push_back(e);
    if (retire) exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== E_ZERO || instret !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h instret %0d, expected %h instret 0", obs, instret, E_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    exp_t e;
    logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] al [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 5; i++) begin
      op = 6'b000000; funct = fn[i];
      push("rtype_fetch", e_fetch(1), 1, 0);
      push("rtype_decode", e_decode(0), 1, 0);
      push("rtype_exec", e_exec(al[i], 0), 1, 0);
      push("rtype_aluwb", E_ALUWB, 1, 1);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        mem_ready = e.rdy;
        #1;
        checks++;
        if (obs !== e.outs || instret !== e.cnt) begin
          errors++;
          $display("[TB] FAIL %s: got %h instret %0d, expected %h instret %0d", e.name, obs, instret, e.outs, e.cnt);
        end
        @(posedge clk); @(negedge clk);
      end
    end
  endtask

  task automatic test_lw_stall();
    exp_t e;
    op = 6'b100011; funct = 6'b000000; zero = 1'b1;
    push("lw_fetch", e_fetch(1), 1, 0);
    push("lw_decode", e_decode(0), 0, 0);
    push("lw_memadr", E_ADDR, 1, 0);
    push("lw_memrd_wait0", E_MEMRD, 0, 0);
    push("lw_memrd_wait1", E_MEMRD, 0, 0);
    push("lw_memrd_wait2", E_MEMRD, 0, 0);
    push("lw_memrd_done", E_MEMRD, 1, 0);
    push("lw_memwb", E_MEMWB, 1, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      #1;
      checks++;
      if (obs !== e.outs || instret !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s: got %h instret %0d, expected %h instret %0d", e.name, obs, instret, e.outs, e.cnt);
      end
      @(posedge clk); @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_fetch_stall();
    exp_t e;
    op = 6'b101011;
    push("sw_fetch_wait", e_fetch(0), 0, 0);
    push("sw_fetch", e_fetch(1), 1, 0);
    push("sw_decode", e_decode(0), 1, 0);
    push("sw_memadr", E_ADDR, 0, 0);
    push("sw_memwr_wait", E_MEMWR, 0, 0);
    push("sw_memwr_done", E_MEMWR, 1, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      #1;
      checks++;
      if (obs !== e.outs || instret !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s: got %h instret %0d, expected %h instret %0d", e.name, obs, instret, e.outs, e.cnt);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_branch_addi_jump();
    exp_t e;
    for (int z = 1; z >= 0; z--) begin
      op = 6'b000100; zero = z[0];
      push("beq_fetch", e_fetch(1), 1, 0);
      push("beq_decode", e_decode(0), 1, 0);
      push("beq_branch", e_branch(z[0]), 1, 1);
    end
    op = 6'b001000;
    push("addi_fetch", e_fetch(1), 1, 0);
    push("addi_decode", e_decode(0), 1, 0);
    push("addi_ex", E_ADDR, 1, 0);
    push("addi_wb", E_ADDIWB, 1, 1);
    push("j_fetch", e_fetch(1), 1, 0);
    push("j_decode", e_decode(0), 1, 0);
    push("j_jump", E_JUMP, 1, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      if (e.name == "beq_fetch") begin
        op = 6'b000100;
        zero = (e.cnt == exp_cnt - 4) ? 1'b1 : 1'b0;
      end
      if (e.name == "addi_fetch") op = 6'b001000;
      if (e.name == "j_fetch") op = 6'b000010;
      #1;
      checks++;
      if (obs !== e.outs || instret !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s: got %h instret %0d, expected %h instret %0d", e.name, obs, instret, e.outs, e.cnt);
      end
      @(posedge clk); @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    exp_t e;
    op = 6'b111111;
    push("illop_fetch", e_fetch(1), 1, 0);
    push("illop_decode", e_decode(1), 1, 0);
    push("illfn_fetch", e_fetch(1), 1, 0);
    push("illfn_decode", e_decode(0), 1, 0);
    push("illfn_exec", e_exec(3'b000, 1), 1, 0);
    push("after_illegal_fetch", e_fetch(0), 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      if (e.name == "illfn_fetch") begin
        op = 6'b000000; funct = 6'b000000;
      end
      #1;
      checks++;
      if (obs !== e.outs || instret !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s: got %h instret %0d, expected %h instret %0d", e.name, obs, instret, e.outs, e.cnt);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_bne();
    exp_t e;
    op = 6'b000101; zero = 1'b0;
    push("bne_fetch", e_fetch(1), 1, 0);
`ifdef MC_CTRL_BNE_EN
    push("bne_decode", e_decode(0), 1, 0);
    push("bne_branch", e_branch(1), 1, 1);
`else
    push("bne_decode_illegal", e_decode(1), 1, 0);
`endif
    push("bne_next_fetch", e_fetch(0), 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      #1;
      checks++;
      if (obs !== e.outs || instret !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s: got %h instret %0d, expected %h instret %0d", e.name, obs, instret, e.outs, e.cnt);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_sw();
    exp_t e;
    op = 6'b101011;
    push("rsw_fetch", e_fetch(1), 1, 0);
    push("rsw_decode", e_decode(0), 1, 0);
    push("rsw_memadr", E_ADDR, 1, 0);
    push("rsw_memwr_wait", E_MEMWR, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      #1;
      checks++;
      if (obs !== e.outs || instret !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s: got %h instret %0d, expected %h instret %0d", e.name, obs, instret, e.outs, e.cnt);
      end
      @(posedge clk); @(negedge clk);
    end
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== E_ZERO || instret !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rsw_async_reset: got %h instret %0d, expected %h instret 0", obs, instret, E_ZERO);
    end
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    push("rsw_after_fetch", e_fetch(0), 0, 0);
    push("rsw_after_fetch_rdy", e_fetch(1), 1, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      #1;
      checks++;
      if (obs !== e.outs || instret !== e.cnt) begin
        errors++;
        $display("[TB] FAIL %s: got %h instret %0d, expected %h instret %0d", e.name, obs, instret, e.outs, e.cnt);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_fetch_stall();
    test_branch_addi_jump();
    test_illegal();
    test_bne();
    test_reset_mid_sw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
